reg_load_seq: RTL and testbench

REG_LOAD_SEQ -- requirements
Module: reg_load_seq

---
 rtl/reg_load_seq.sv | 149 ++++++++++++++
 tb/tb_reg_load_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reg_load_seq.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXE/MEM/WB/HALTED with load strobes.
// Optional retired-instruction counter enabled by defining RLS_INSTR_CNT_EN.
module reg_load_seq (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READY,
    input  logic [1:0]  OP_CLASS,
    input  logic        HALT,
    output logic [2:0]  STATE,
    output logic        PC_LOAD,
    output logic        IR_LOAD,
    output logic        RF_LOAD,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [31:0] INSTR_CNT
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXE    = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   pc_load_s;
    logic   ir_load_s;
    logic   rf_load_s;
    logic   mem_read_s;
    logic   mem_write_s;

    // Next-state and raw strobe decode from current state and inputs
    always_comb begin
        state_d     = ST_FETCH;
        pc_load_s   = 1'b0;
        ir_load_s   = 1'b0;
        rf_load_s   = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read_s = 1'b1;
                if (MEM_READY) begin
                    ir_load_s = 1'b1;
                    state_d   = ST_DECODE;
                end else begin
                    state_d   = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (HALT) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_EXE;
                end
            end
            ST_EXE: begin
                case (OP_CLASS)
                    2'b00:   state_d = ST_WB;
                    2'b01:   state_d = ST_MEM;
                    2'b10:   state_d = ST_MEM;
                    2'b11: begin
                        pc_load_s = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                // OP_CLASS is held by upstream, so it still selects load vs store here
                case (OP_CLASS)
                    2'b01: begin
                        mem_read_s = 1'b1;
                        if (MEM_READY) begin
                            state_d = ST_WB;
                        end else begin
                            state_d = ST_MEM;
                        end
                    end
                    2'b10: begin
                        mem_write_s = 1'b1;
                        if (MEM_READY) begin
                            pc_load_s = 1'b1;
                            state_d   = ST_FETCH;
                        end else begin
                            state_d   = ST_MEM;
                        end
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_WB: begin
                rf_load_s = 1'b1;
                pc_load_s = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are forced low combinationally while reset is asserted
    assign PC_LOAD   = RESET & pc_load_s;
    assign IR_LOAD   = RESET & ir_load_s;
    assign RF_LOAD   = RESET & rf_load_s;
    assign MEM_READ  = RESET & mem_read_s;
    assign MEM_WRITE = RESET & mem_write_s;
    assign STATE     = state_q;

`ifdef RLS_INSTR_CNT_EN
    logic [31:0] instr_cnt_q;
    logic [31:0] instr_cnt_d;

    // One retire per PC load; wraps naturally at 32 bits
    always_comb begin
        if (PC_LOAD) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end else begin
            instr_cnt_d = instr_cnt_q;
        end
    end

    // Retired-instruction counter register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            instr_cnt_q <= 32'd0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign INSTR_CNT = instr_cnt_q;
`else
    assign INSTR_CNT = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_reg_load_seq.sv
// Directed self-checking bench for reg_load_seq; counter expectations follow RLS_INSTR_CNT_EN.
module tb_reg_load_seq;

    logic        CLK;
    logic        RESET;
    logic        MEM_READY;
    logic [1:0]  OP_CLASS;
    logic        HALT;
    logic [2:0]  STATE;
    logic        PC_LOAD;
    logic        IR_LOAD;
    logic        RF_LOAD;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] INSTR_CNT;

    int total;
    int bad;
    int retired;

    reg_load_seq dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .MEM_READY (MEM_READY),
        .OP_CLASS  (OP_CLASS),
        .HALT      (HALT),
        .STATE     (STATE),
        .PC_LOAD   (PC_LOAD),
        .IR_LOAD   (IR_LOAD),
        .RF_LOAD   (RF_LOAD),
        .MEM_READ  (MEM_READ),
        .MEM_WRITE (MEM_WRITE),
        .INSTR_CNT (INSTR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // strb order: pc, ir, rf, rd, wr
    task automatic chk(input string tag, input logic [2:0] st, input logic [4:0] strb);
        logic [7:0] obs;
        logic [7:0] exp;
        #1;
        obs = {STATE, PC_LOAD, IR_LOAD, RF_LOAD, MEM_READ, MEM_WRITE};
        exp = {st, strb};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        logic [31:0] exp;
`ifdef RLS_INSTR_CNT_EN
        exp = 32'(retired);
`else
        exp = 32'h0000_0000;
`endif
        total++;
        assert (INSTR_CNT === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, INSTR_CNT, exp);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        retired   = 0;
        RESET     = 1'b0;
        MEM_READY = 1'b1;
        OP_CLASS  = 2'b00;
        HALT      = 1'b0;

        // reset held: FETCH state but all strobes forced low
        tick();
        chk("rst_hold", 3'd0, 5'b00000);
        chk_cnt("rst_cnt");

        // ALU instruction: 0,1,2,4,0
        tick(); RESET = 1'b1;
        chk("alu_fetch", 3'd0, 5'b01010);
        tick();
        chk("alu_decode", 3'd1, 5'b00000);
        tick();
        chk("alu_exe", 3'd2, 5'b00000);
        tick();
        chk("alu_wb", 3'd4, 5'b10100);
        tick(); retired = 1;
        chk("alu_back", 3'd0, 5'b01010);
        chk_cnt("alu_cnt");

        // load with three wait cycles in MEM
        tick(); OP_CLASS = 2'b01;
        chk("ld_decode", 3'd1, 5'b00000);
        tick();
        chk("ld_exe", 3'd2, 5'b00000);
        tick(); MEM_READY = 1'b0;
        chk("ld_mem_w1", 3'd3, 5'b00010);
        tick();
        chk("ld_mem_w2", 3'd3, 5'b00010);
        tick();
        chk("ld_mem_w3", 3'd3, 5'b00010);
        tick(); MEM_READY = 1'b1;
        chk("ld_mem_done", 3'd3, 5'b00010);
        tick();
        chk("ld_wb", 3'd4, 5'b10100);
        tick(); retired = 2;
        chk("ld_back", 3'd0, 5'b01010);
        chk_cnt("ld_cnt");

        // store without wait: PC_LOAD in the MEM cycle
        tick(); OP_CLASS = 2'b10;
        chk("st_decode", 3'd1, 5'b00000);
        tick();
        chk("st_exe", 3'd2, 5'b00000);
        tick();
        chk("st_mem", 3'd3, 5'b10001);
        tick(); retired = 3;
        chk("st_back", 3'd0, 5'b01010);
        chk_cnt("st_cnt");

        // branch: PC_LOAD in EXE, 3-cycle loop
        tick(); OP_CLASS = 2'b11;
        chk("br_decode", 3'd1, 5'b00000);
        tick();
        chk("br_exe", 3'd2, 5'b10000);
        tick(); retired = 4;
        chk("br_back", 3'd0, 5'b01010);
        chk_cnt("br_cnt");

        // halt: stay in HALTED regardless of inputs
        tick(); HALT = 1'b1; OP_CLASS = 2'b00;
        chk("halt_decode", 3'd1, 5'b00000);
        for (int i = 0; i < 12; i++) begin
            tick();
            HALT      = i[0];
            MEM_READY = i[1];
            chk("halted", 3'd5, 5'b00000);
        end
        chk_cnt("halt_cnt");
        RESET = 1'b0;
        chk("halt_rst_comb", 3'd5, 5'b00000);
        tick(); retired = 0;
        chk("halt_rst_state", 3'd0, 5'b00000);
        chk_cnt("halt_rst_cnt");
        HALT = 1'b0; MEM_READY = 1'b0; RESET = 1'b1;
        chk("post_rst_fetch", 3'd0, 5'b00010);

        // reset during FETCH wait
        tick();
        chk("fetch_wait", 3'd0, 5'b00010);
        RESET = 1'b0;
        chk("fetch_wait_rst", 3'd0, 5'b00000);
        tick(); RESET = 1'b1; MEM_READY = 1'b1;
        chk("fetch_wait_back", 3'd0, 5'b01010);

        // reset during load MEM wait overrides the hold
        tick(); OP_CLASS = 2'b01;
        chk("ld2_decode", 3'd1, 5'b00000);
        tick();
        chk("ld2_exe", 3'd2, 5'b00000);
        tick(); MEM_READY = 1'b0;
        chk("ld2_mem_wait", 3'd3, 5'b00010);
        RESET = 1'b0;
        chk("ld2_mem_rst", 3'd3, 5'b00000);
        tick(); RESET = 1'b1;
        chk("ld2_after_rst", 3'd0, 5'b00010);
        chk_cnt("ld2_cnt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
